// File: rtl/xmem_fifo_bridge_if.sv
// ============================================================================
// Module      : xmem_fifo_bridge_if
// Description : AVR external-memory window plus backend byte-stream signals.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface xmem_fifo_bridge_if;
  logic [15:0] sram_a;
  logic [7:0]  sram_d_out;
  logic [7:0]  sram_d_in;
  logic        sram_cs;
  logic        sram_oe;
  logic        sram_we;
  logic        sram_wait;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // CPU and backend side
  modport master (
    output sram_a, sram_d_out, sram_cs, sram_oe, sram_we,
    output rx_data, rx_strobe, tx_ready,
    input  sram_d_in, sram_wait, tx_data, tx_valid
  );

  // Bridge side
  modport slave (
    input  sram_a, sram_d_out, sram_cs, sram_oe, sram_we,
    input  rx_data, rx_strobe, tx_ready,
    output sram_d_in, sram_wait, tx_data, tx_valid
  );
endinterface

`default_nettype wire

// File: rtl/xmem_fifo_bridge.sv
// ============================================================================
// Module      : xmem_fifo_bridge
// Description : Memory-mapped RX/TX byte FIFOs on the AVR xmem window with
//               wait-state stalling of blocked DATA accesses.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module xmem_fifo_bridge #(
  parameter int FIFO_DEPTH   = 16,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  xmem_fifo_bridge_if.slave  bus
);

  localparam int              c_AW   = $clog2(FIFO_DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
  localparam logic [15:0]     c_TMO  = 16'(WAIT_TIMEOUT);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_RD_BLOCK = 2'd1;
  localparam logic [1:0] c_WR_BLOCK = 2'd2;
  localparam logic [1:0] c_DONE     = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [15:0]     r_tmo;
  logic [7:0]      r_d_in;

  logic [7:0]      r_rx_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_rx_rd;
  logic [c_AW-1:0] r_rx_wr;
  logic [c_CW-1:0] r_rx_cnt;
  logic [7:0]      r_tx_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_tx_rd;
  logic [c_AW-1:0] r_tx_wr;
  logic [c_CW-1:0] r_tx_cnt;

  logic            r_rx_overflow;
  logic            r_rx_underrun;
  logic            r_tx_drop;

  logic            w_rd_acc;
  logic            w_wr_acc;
  logic [2:0]      w_off;
  logic            w_is_data;
  logic            w_tmo_hit;
  logic            w_rx_empty;
  logic            w_rx_full;
  logic            w_tx_empty;
  logic            w_tx_full;
  logic            w_tx_space;

  logic            w_wait;
  logic            w_cap_en;
  logic            w_cap_zero;
  logic            w_rx_pop;
  logic            w_cpu_push;
  logic            w_reg_wr;
  logic            w_und_set;
  logic            w_drop_set;

  logic            w_sts_wr;
  logic            w_rx_flush;
  logic            w_tx_flush;
  logic            w_rx_pop_ok;
  logic            w_rx_push_ok;
  logic            w_rx_ovf_set;
  logic            w_tx_pop_ok;
  logic            w_tx_push_ok;
  logic [7:0]      w_status;
  logic [7:0]      w_rd_val;
  logic            w_unused_addr;

  assign w_rd_acc      = bus.sram_cs & bus.sram_oe;
  assign w_wr_acc      = bus.sram_cs & bus.sram_we;
  assign w_off         = bus.sram_a[2:0];
  assign w_is_data     = (w_off == 3'd0);
  assign w_tmo_hit     = (r_tmo == c_TMO);
  assign w_unused_addr = ^bus.sram_a[15:3];

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == c_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == c_FULL);

  assign w_sts_wr   = w_reg_wr & (w_off == 3'd1);
  assign w_rx_flush = w_reg_wr & (w_off == 3'd4) & bus.sram_d_out[0];
  assign w_tx_flush = w_reg_wr & (w_off == 3'd4) & bus.sram_d_out[1];

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign w_rx_pop_ok  = w_rx_pop & ~w_rx_empty & ~w_rx_flush;
  assign w_rx_push_ok = bus.rx_strobe & ~w_rx_flush & (~w_rx_full | w_rx_pop_ok);
  assign w_rx_ovf_set = bus.rx_strobe & ~w_rx_flush & w_rx_full & ~w_rx_pop_ok;

  assign w_tx_pop_ok  = bus.tx_ready & ~w_tx_empty & ~w_tx_flush;
  assign w_tx_space   = ~w_tx_full | w_tx_pop_ok;
  assign w_tx_push_ok = w_cpu_push & ~w_tx_flush & w_tx_space;

  assign w_status = {2'b00, r_tx_drop, w_tx_empty, r_rx_underrun,
                     r_rx_overflow, w_tx_full, ~w_rx_empty};

  always_comb begin
    w_rd_val = 8'h00;
    case (w_off)
      3'd0:    w_rd_val = r_rx_mem[r_rx_rd];
      3'd1:    w_rd_val = w_status;
      3'd2:    w_rd_val = 8'(r_rx_cnt);
      3'd3:    w_rd_val = 8'(r_tx_cnt);
      default: w_rd_val = 8'h00;
    endcase
  end

  // --------------------------------------------------------------------------
  // Access FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_rd_acc) begin
          w_next = (!w_is_data || !w_rx_empty) ? c_DONE : c_RD_BLOCK;
        end else if (w_wr_acc && w_is_data && w_tx_full) begin
          w_next = c_WR_BLOCK;
        end
      end
      c_RD_BLOCK: begin
        if (!w_rd_acc) begin
          w_next = c_IDLE;
        end else if (!w_rx_empty || w_tmo_hit) begin
          w_next = c_DONE;
        end
      end
      c_WR_BLOCK: begin
        if (!w_wr_acc || w_tx_space || w_tmo_hit) begin
          w_next = c_IDLE;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_wait     = 1'b0;
    w_cap_en   = 1'b0;
    w_cap_zero = 1'b0;
    w_rx_pop   = 1'b0;
    w_cpu_push = 1'b0;
    w_reg_wr   = 1'b0;
    w_und_set  = 1'b0;
    w_drop_set = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_rd_acc) begin
          w_wait = 1'b1;
          if (!w_is_data || !w_rx_empty) begin
            w_cap_en = 1'b1;
            w_rx_pop = w_is_data;
          end
        end else if (w_wr_acc) begin
          if (!w_is_data) begin
            w_reg_wr = 1'b1;
          end else if (w_tx_full) begin
            w_wait = 1'b1;
          end else begin
            w_cpu_push = 1'b1;
          end
        end
      end
      c_RD_BLOCK: begin
        w_wait = 1'b1;
        if (w_rd_acc) begin
          if (!w_rx_empty) begin
            w_cap_en = 1'b1;
            w_rx_pop = 1'b1;
          end else if (w_tmo_hit) begin
            w_cap_en   = 1'b1;
            w_cap_zero = 1'b1;
            w_und_set  = 1'b1;
          end
        end
      end
      c_WR_BLOCK: begin
        w_wait = 1'b1;
        if (w_wr_acc) begin
          if (w_tx_space) begin
            w_cpu_push = 1'b1;
          end else if (w_tmo_hit) begin
            w_drop_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Counts stall cycles; the first blocked cycle sees 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= 16'd0;
    end else if (r_state == c_IDLE || r_state == c_DONE) begin
      r_tmo <= 16'd1;
    end else begin
      r_tmo <= r_tmo + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_in <= 8'h00;
    end else if (w_cap_en) begin
      r_d_in <= w_cap_zero ? 8'h00 : w_rd_val;
    end
  end

  // Sticky flags: a same-cycle set beats a write-one-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_overflow <= 1'b0;
      r_rx_underrun <= 1'b0;
      r_tx_drop     <= 1'b0;
    end else begin
      r_rx_overflow <= (r_rx_overflow & ~(w_sts_wr & bus.sram_d_out[2])) | w_rx_ovf_set;
      r_rx_underrun <= (r_rx_underrun & ~(w_sts_wr & bus.sram_d_out[3])) | w_und_set;
      r_tx_drop     <= (r_tx_drop     & ~(w_sts_wr & bus.sram_d_out[5])) | w_drop_set;
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_rx_push_ok) begin
      r_rx_mem[r_rx_wr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_cnt <= '0;
    end else if (w_rx_flush) begin
      r_rx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push_ok) begin
        r_rx_wr <= r_rx_wr + c_AW'(1);
      end
      if (w_rx_pop_ok) begin
        r_rx_rd <= r_rx_rd + c_AW'(1);
      end
      case ({w_rx_push_ok, w_rx_pop_ok})
        2'b10:   r_rx_cnt <= r_rx_cnt + c_CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - c_CW'(1);
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_tx_push_ok) begin
      r_tx_mem[r_tx_wr] <= bus.sram_d_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
    end else if (w_tx_flush) begin
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push_ok) begin
        r_tx_wr <= r_tx_wr + c_AW'(1);
      end
      if (w_tx_pop_ok) begin
        r_tx_rd <= r_tx_rd + c_AW'(1);
      end
      case ({w_tx_push_ok, w_tx_pop_ok})
        2'b10:   r_tx_cnt <= r_tx_cnt + c_CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - c_CW'(1);
        default: ;
      endcase
    end
  end

  // Wait is forced low during reset so a held strobe cannot stall the CPU.
  assign bus.sram_wait = w_wait & ~rst;
  assign bus.sram_d_in = r_d_in;
  assign bus.tx_valid  = ~w_tx_empty;
  assign bus.tx_data   = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];

endmodule

`default_nettype wire
